tbird_lamp_monitor: RTL and testbench

- Passive checker at the far end of the Thunderbird tail-light interface. It consumes the six lamp lines (Lc Lb La Ra Rb Rc) that the turn-signal FSM drives.
- Reconstructs which turn sequence is running, checks step order and step timing against the legal Thunderbird patterns, and counts completed left and right sequences.
- Used in-system for lamp-fault detection and in benches as a self-checking monitor on the FSM.

---
 rtl/thunderbird_pkg.sv | 51 +++++
 rtl/tbird_lamp_monitor.sv | 179 +++++++++++++++++
 tb/tb_tbird_lamp_monitor.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/thunderbird_pkg.sv
// Shared types and constants for the Thunderbird tail-light lamp monitor.
package thunderbird_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_L1,
    S_L2,
    S_L3,
    S_R1,
    S_R2,
    S_R3,
    HUNT
  } mon_state_e;

  typedef enum logic [2:0] {
    P_OFF,
    P_L1,
    P_L2,
    P_L3,
    P_R1,
    P_R2,
    P_R3,
    P_ILLEGAL
  } lamp_pat_e;

  // Lamp vectors are packed as {Lc, Lb, La, Ra, Rb, Rc}.
  localparam logic [5:0] PAT_OFF = 6'b000_000;
  localparam logic [5:0] PAT_L1  = 6'b001_000;
  localparam logic [5:0] PAT_L2  = 6'b011_000;
  localparam logic [5:0] PAT_L3  = 6'b111_000;
  localparam logic [5:0] PAT_R1  = 6'b000_100;
  localparam logic [5:0] PAT_R2  = 6'b000_110;
  localparam logic [5:0] PAT_R3  = 6'b000_111;

  // Map a raw six-lamp vector onto one of the legal patterns or ILLEGAL.
  function automatic lamp_pat_e classifyLamps(input logic [5:0] lamps);
    lamp_pat_e result;
    case (lamps)
      PAT_OFF: result = P_OFF;
      PAT_L1:  result = P_L1;
      PAT_L2:  result = P_L2;
      PAT_L3:  result = P_L3;
      PAT_R1:  result = P_R1;
      PAT_R2:  result = P_R2;
      PAT_R3:  result = P_R3;
      default: result = P_ILLEGAL;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tbird_lamp_monitor.sv
// Passive checker for the Thunderbird tail-light lamp lines: tracks the
// running turn sequence, checks step order and dwell time, and counts
// completed left and right sequences.
import thunderbird_pkg::*;

module tbird_lamp_monitor #(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Lc,
  input  logic             Lb,
  input  logic             La,
  input  logic             Ra,
  input  logic             Rb,
  input  logic             Rc,
  input  logic             clr_err,
  output logic             active_left,
  output logic             active_right,
  output logic             done_pulse,
  output logic             abort_pulse,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt
);

  localparam int HOLD_W = $clog2(STEP_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STEP_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  mon_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  lcnt_q, lcnt_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;

  lamp_pat_e  pat;
  lamp_pat_e  curPat;
  lamp_pat_e  nxtPat;
  mon_state_e nxtState;
  logic       lastStep;
  logic       leftSide;

  assign pat = classifyLamps({Lc, Lb, La, Ra, Rb, Rc});

  // Describe the step the monitor is currently in: expected pattern, the
  // pattern that may follow it, and whether it is the final step.
  always_comb begin
    curPat   = P_OFF;
    nxtPat   = P_OFF;
    nxtState = IDLE;
    lastStep = 1'b0;
    leftSide = 1'b0;
    case (state_q)
      S_L1: begin curPat = P_L1; nxtPat = P_L2; nxtState = S_L2; leftSide = 1'b1; end
      S_L2: begin curPat = P_L2; nxtPat = P_L3; nxtState = S_L3; leftSide = 1'b1; end
      S_L3: begin curPat = P_L3; nxtPat = P_L3; lastStep = 1'b1; leftSide = 1'b1; end
      S_R1: begin curPat = P_R1; nxtPat = P_R2; nxtState = S_R2; end
      S_R2: begin curPat = P_R2; nxtPat = P_R3; nxtState = S_R3; end
      S_R3: begin curPat = P_R3; nxtPat = P_R3; lastStep = 1'b1; end
      default: begin end
    endcase
  end

  // Next-state, event pulses and counter updates for the sampled pattern.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    err_d   = 1'b0;
    lcnt_d  = lcnt_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (pat == P_L1) begin
          state_d = S_L1;
          hold_d  = HOLD_ONE;
        end else if (pat == P_R1) begin
          state_d = S_R1;
          hold_d  = HOLD_ONE;
        end else if (pat != P_OFF) begin
          err_d   = 1'b1;
          state_d = HUNT;
          hold_d  = '0;
        end
      end
      HUNT: begin
        if (pat == P_OFF) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (pat == curPat) begin
          if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            hold_d  = '0;
          end
        end else if (!lastStep && pat == nxtPat) begin
          if (hold_q == HOLD_MAX) begin
            state_d = nxtState;
            hold_d  = HOLD_ONE;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            hold_d  = '0;
          end
        end else if (pat == P_OFF) begin
          state_d = IDLE;
          hold_d  = '0;
          if (lastStep && hold_q == HOLD_MAX) begin
            done_d = 1'b1;
            if (leftSide && lcnt_q != CNT_MAX) lcnt_d = lcnt_q + CNT_ONE;
            if (!leftSide && rcnt_q != CNT_MAX) rcnt_d = rcnt_q + CNT_ONE;
          end else begin
            abort_d = 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = HUNT;
          hold_d  = '0;
        end
      end
    endcase
  end

  // A fresh error takes priority over a clear arriving in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (err_d) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end
  end

  // State, hold counter and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      lcnt_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      lcnt_q   <= lcnt_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign active_left  = (state_q == S_L1) || (state_q == S_L2) || (state_q == S_L3);
  assign active_right = (state_q == S_R1) || (state_q == S_R2) || (state_q == S_R3);
  assign done_pulse   = done_q;
  assign abort_pulse  = abort_q;
  assign err_pulse    = err_q;
  assign err_sticky   = sticky_q;
  assign left_cnt     = lcnt_q;
  assign right_cnt    = rcnt_q;

endmodule

// File: tb/tb_tbird_lamp_monitor.sv
// Directed self-checking bench for tbird_lamp_monitor. Three instances share
// the lamp stimulus: the default configuration, a two-cycle step time, and a
// two-bit counter width for saturation.
module tb_tbird_lamp_monitor;

  localparam logic [5:0] OFF = 6'b000_000;
  localparam logic [5:0] L1  = 6'b001_000;
  localparam logic [5:0] L2  = 6'b011_000;
  localparam logic [5:0] L3  = 6'b111_000;
  localparam logic [5:0] R1  = 6'b000_100;
  localparam logic [5:0] R2  = 6'b000_110;
  localparam logic [5:0] R3  = 6'b000_111;
  localparam logic [5:0] HAZ = 6'b001_100;
  localparam logic [5:0] ALL = 6'b111_111;

  logic       clk;
  logic       reset;
  logic       clrErr;
  logic [5:0] lamps;

  int errors;
  int checks;

  logic       aL1, aR1, dn1, ab1, er1, st1;
  logic [7:0] lc1, rc1;
  logic       aL2, aR2, dn2, ab2, er2, st2;
  logic [7:0] lc2, rc2;
  logic       aL3, aR3, dn3, ab3, er3, st3;
  logic [1:0] lc3, rc3;

  tbird_lamp_monitor #(.STEP_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .Lc(lamps[5]), .Lb(lamps[4]), .La(lamps[3]),
    .Ra(lamps[2]), .Rb(lamps[1]), .Rc(lamps[0]),
    .clr_err(clrErr),
    .active_left(aL1), .active_right(aR1), .done_pulse(dn1),
    .abort_pulse(ab1), .err_pulse(er1), .err_sticky(st1),
    .left_cnt(lc1), .right_cnt(rc1)
  );

  tbird_lamp_monitor #(.STEP_CYCLES(2), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset),
    .Lc(lamps[5]), .Lb(lamps[4]), .La(lamps[3]),
    .Ra(lamps[2]), .Rb(lamps[1]), .Rc(lamps[0]),
    .clr_err(clrErr),
    .active_left(aL2), .active_right(aR2), .done_pulse(dn2),
    .abort_pulse(ab2), .err_pulse(er2), .err_sticky(st2),
    .left_cnt(lc2), .right_cnt(rc2)
  );

  tbird_lamp_monitor #(.STEP_CYCLES(1), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset),
    .Lc(lamps[5]), .Lb(lamps[4]), .La(lamps[3]),
    .Ra(lamps[2]), .Rb(lamps[1]), .Rc(lamps[0]),
    .clr_err(clrErr),
    .active_left(aL3), .active_right(aR3), .done_pulse(dn3),
    .abort_pulse(ab3), .err_pulse(er3), .err_sticky(st3),
    .left_cnt(lc3), .right_cnt(rc3)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one lamp pattern, let it be sampled, and settle past the edge.
  task automatic applyStimulus(input logic [5:0] p);
    lamps = p;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetPulse();
    lamps  = OFF;
    clrErr = 1'b0;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    clrErr = 1'b0;
    lamps  = OFF;

    #21;
    checkOutput("rst_active_left", 32'(aL1), 0);
    checkOutput("rst_done", 32'(dn1), 0);
    checkOutput("rst_err_sticky", 32'(st1), 0);
    checkOutput("rst_left_cnt", 32'(lc1), 0);
    checkOutput("rst_right_cnt", 32'(rc1), 0);
    #1;
    reset = 1'b1;

    $display("[TB] left sequence, one-cycle steps");
    applyStimulus(OFF);
    checkOutput("idle_active_left", 32'(aL1), 0);
    applyStimulus(L1);
    checkOutput("L1_active_left", 32'(aL1), 1);
    applyStimulus(L2);
    checkOutput("L2_active_left", 32'(aL1), 1);
    applyStimulus(L3);
    checkOutput("L3_active_left", 32'(aL1), 1);
    checkOutput("L3_done", 32'(dn1), 0);
    applyStimulus(OFF);
    checkOutput("left_done", 32'(dn1), 1);
    checkOutput("left_done_active", 32'(aL1), 0);
    checkOutput("left_cnt_1", 32'(lc1), 1);
    checkOutput("left_err_sticky", 32'(st1), 0);
    applyStimulus(OFF);
    checkOutput("left_done_clears", 32'(dn1), 0);

    $display("[TB] three right sequences");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(R1);
      checkOutput("right_active_right", 32'(aR1), 1);
      checkOutput("right_active_left", 32'(aL1), 0);
      applyStimulus(R2);
      applyStimulus(R3);
      applyStimulus(OFF);
      checkOutput("right_done", 32'(dn1), 1);
      checkOutput("right_cnt_run", 32'(rc1), 32'(i));
    end
    checkOutput("right_left_cnt_unchanged", 32'(lc1), 1);

    $display("[TB] abort");
    applyStimulus(L1);
    applyStimulus(L2);
    applyStimulus(OFF);
    checkOutput("abort_pulse", 32'(ab1), 1);
    checkOutput("abort_no_done", 32'(dn1), 0);
    checkOutput("abort_left_cnt", 32'(lc1), 1);
    checkOutput("abort_idle", 32'(aL1), 0);
    applyStimulus(OFF);
    checkOutput("abort_one_cycle", 32'(ab1), 0);

    $display("[TB] illegal hazard pattern");
    applyStimulus(L1);
    applyStimulus(HAZ);
    checkOutput("haz_err_pulse", 32'(er1), 1);
    checkOutput("haz_err_sticky", 32'(st1), 1);
    checkOutput("haz_active_left", 32'(aL1), 0);
    applyStimulus(L2);
    checkOutput("hunt_L2_err", 32'(er1), 0);
    checkOutput("hunt_L2_active", 32'(aL1), 0);
    applyStimulus(L3);
    checkOutput("hunt_L3_active", 32'(aL1), 0);
    checkOutput("hunt_L3_sticky", 32'(st1), 1);
    applyStimulus(OFF);
    checkOutput("hunt_exit_abort", 32'(ab1), 0);
    checkOutput("hunt_exit_done", 32'(dn1), 0);
    checkOutput("hunt_exit_cnt", 32'(lc1), 1);
    applyStimulus(L1);
    checkOutput("hunt_back_idle", 32'(aL1), 1);
    applyStimulus(OFF);
    clrErr = 1'b1;
    applyStimulus(OFF);
    checkOutput("clr_sticky", 32'(st1), 0);
    applyStimulus(ALL);
    checkOutput("clr_vs_err_pulse", 32'(er1), 1);
    checkOutput("clr_vs_err_sticky", 32'(st1), 1);
    applyStimulus(OFF);
    checkOutput("clr_after_hunt", 32'(st1), 0);
    clrErr = 1'b0;

    $display("[TB] two-cycle step timing");
    resetPulse();
    checkOutput("t2_reset_cnt", 32'(lc2), 0);
    applyStimulus(L1);
    applyStimulus(L1);
    checkOutput("t2_L1_hold", 32'(aL2), 1);
    checkOutput("t2_L1_noerr", 32'(er2), 0);
    applyStimulus(L2);
    applyStimulus(L2);
    applyStimulus(L3);
    applyStimulus(L3);
    checkOutput("t2_L3_active", 32'(aL2), 1);
    applyStimulus(OFF);
    checkOutput("t2_done", 32'(dn2), 1);
    checkOutput("t2_left_cnt", 32'(lc2), 1);
    checkOutput("t2_sticky", 32'(st2), 0);
    applyStimulus(L1);
    applyStimulus(L2);
    checkOutput("t2_understay", 32'(er2), 1);
    applyStimulus(OFF);
    applyStimulus(L1);
    applyStimulus(L1);
    checkOutput("t2_pre_overstay", 32'(er2), 0);
    applyStimulus(L1);
    checkOutput("t2_overstay", 32'(er2), 1);
    checkOutput("t2_overstay_cnt", 32'(lc2), 1);
    applyStimulus(OFF);

    $display("[TB] counter saturation and reset mid-sequence");
    resetPulse();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(L1);
      applyStimulus(L2);
      applyStimulus(L3);
      applyStimulus(OFF);
      checkOutput("sat_left_cnt", 32'(lc3), (i < 3) ? 32'(i) : 32'd3);
    end
    applyStimulus(L1);
    applyStimulus(L2);
    checkOutput("mid_active_left", 32'(aL3), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_active_left", 32'(aL3), 0);
    checkOutput("async_left_cnt", 32'(lc3), 0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_done", 32'(dn3), 0);
    checkOutput("rst_hold_abort", 32'(ab3), 0);
    lamps = OFF;
    reset = 1'b1;
    applyStimulus(OFF);
    checkOutput("post_rst_done", 32'(dn3), 0);
    checkOutput("post_rst_abort", 32'(ab3), 0);
    checkOutput("post_rst_cnt", 32'(lc3), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
